// File: rtl/phase_run_controller_if.sv
// Button/datapath-facing bundle for the phase run controller.
`timescale 1ns/1ps
interface phase_run_controller_if #(
  parameter int AW = 16
);
  logic          exec;
  logic          step;
  logic          halt_in;
  logic          bp_en;
  logic [AW-1:0] bp_addr;
  logic [AW-1:0] pc;
  logic [2:0]    phase;
  logic          executing;
  logic          ir_load;
  logic          pc_e;
  logic [1:0]    stop_cause;
  logic [15:0]   instr_count;

  modport master (
    output exec, step, halt_in, bp_en, bp_addr, pc,
    input  phase, executing, ir_load, pc_e, stop_cause, instr_count
  );

  modport slave (
    input  exec, step, halt_in, bp_en, bp_addr, pc,
    output phase, executing, ir_load, pc_e, stop_cause, instr_count
  );
endinterface

// File: rtl/phase_run_controller.sv
// Instruction-phase sequencer for the multi-cycle core: run/stop, single-step, halt and breakpoint.
// Buttons are synchronised then edge-detected; ir_load/pc_e are registered from next-state.
`timescale 1ns/1ps
module phase_run_controller #(
  parameter int NUM_PHASES  = 5,
  parameter int AW          = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic                   clk,
  input logic                   rst,
  phase_run_controller_if.slave bus
);
  localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES);
  localparam logic [2:0] PC_PHASE   = 3'(NUM_PHASES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_nxt;
  logic [2:0]  phase_q, phase_nxt;
  logic        stop_pending_q, stop_pending_nxt;
  logic [1:0]  stop_cause_q, stop_cause_nxt;
  logic [15:0] instr_count_q, instr_count_nxt;
  logic        ir_load_q, pc_e_q;

  logic [SYNC_STAGES-1:0] exec_sync, step_sync;
  logic                   exec_last, step_last;
  logic                   exec_pulse, step_pulse;
  logic [AW-1:0]          pc_v, bp_v;
  logic                   bp_hit, exit_run;

  assign pc_v     = bus.pc;
  assign bp_v     = bus.bp_addr;
  assign bp_hit   = bus.bp_en && (pc_v == bp_v);
  assign exit_run = stop_pending_q || exec_pulse || bus.halt_in || bp_hit;

  // Pulses are registered, so a button edge costs SYNC_STAGES+1 cycles before the FSM sees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_sync  <= '0;
      step_sync  <= '0;
      exec_last  <= 1'b0;
      step_last  <= 1'b0;
      exec_pulse <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      exec_sync  <= {exec_sync[SYNC_STAGES-2:0], bus.exec};
      step_sync  <= {step_sync[SYNC_STAGES-2:0], bus.step};
      exec_last  <= exec_sync[SYNC_STAGES-1];
      step_last  <= step_sync[SYNC_STAGES-1];
      exec_pulse <= exec_sync[SYNC_STAGES-1] & ~exec_last;
      step_pulse <= step_sync[SYNC_STAGES-1] & ~step_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      phase_q        <= 3'd0;
      stop_pending_q <= 1'b0;
      stop_cause_q   <= 2'd0;
      instr_count_q  <= 16'd0;
      ir_load_q      <= 1'b0;
      pc_e_q         <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      phase_q        <= phase_nxt;
      stop_pending_q <= stop_pending_nxt;
      stop_cause_q   <= stop_cause_nxt;
      instr_count_q  <= instr_count_nxt;
      ir_load_q      <= (phase_nxt == 3'd1);
      pc_e_q         <= (phase_nxt == PC_PHASE);
    end
  end

  always_comb begin
    state_nxt        = state_q;
    phase_nxt        = phase_q;
    stop_pending_nxt = stop_pending_q;
    stop_cause_nxt   = stop_cause_q;
    instr_count_nxt  = instr_count_q;
    case (state_q)
      IDLE: begin
        // Exec wins over a simultaneous step; the breakpoint is not looked at on start.
        if (exec_pulse || step_pulse) begin
          state_nxt        = RUN;
          phase_nxt        = 3'd1;
          stop_cause_nxt   = 2'd0;
          stop_pending_nxt = ~exec_pulse;
        end
      end
      RUN: begin
        if (phase_q != LAST_PHASE) begin
          phase_nxt = phase_q + 3'd1;
          if (exec_pulse) stop_pending_nxt = 1'b1;
        end else begin
          instr_count_nxt = instr_count_q + 16'd1;
          phase_nxt       = 3'd1;
          if (exit_run) begin
            state_nxt        = IDLE;
            phase_nxt        = 3'd0;
            stop_pending_nxt = 1'b0;
            if (stop_pending_q || exec_pulse) stop_cause_nxt = 2'd1;
            else if (bus.halt_in)             stop_cause_nxt = 2'd2;
            else                              stop_cause_nxt = 2'd3;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.phase       = phase_q;
  assign bus.executing   = (state_q == RUN);
  assign bus.ir_load     = ir_load_q;
  assign bus.pc_e        = pc_e_q;
  assign bus.stop_cause  = stop_cause_q;
  assign bus.instr_count = instr_count_q;
endmodule

// File: tb/tb_phase_run_controller.sv
// Bench for phase_run_controller: phase trace and stop events are scoreboarded in queues.
`timescale 1ns/1ps
module tb_phase_run_controller;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phase_run_controller_if #(.AW(16)) bus ();

  phase_run_controller #(.NUM_PHASES(5), .AW(16), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]  cause;
    logic [15:0] count;
  } stop_t;

  stop_t stop_q[$];
  int    trace_q[$];
  int    checks = 0;
  int    fails  = 0;

  // Press a button at a falling edge and release it one cycle later.
  task automatic press(input bit use_step);
    if (use_step) bus.step = 1'b1;
    else          bus.exec = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    bus.exec = 1'b0;
  endtask

  // Returns at the falling edge where phase 1 of the first instruction is visible.
  task automatic start_run(input bit use_step);
    press(use_step);
    repeat (3) @(negedge clk);
  endtask

  // Models the datapath PC: it advances on every cycle pc_e is seen.
  task automatic run_until_idle(input int budget, output bit timed_out);
    int n = 0;
    timed_out = 1'b0;
    while (bus.executing === 1'b1) begin
      if (n >= budget) begin
        timed_out = 1'b1;
        break;
      end
      if (bus.pc_e === 1'b1) bus.pc = bus.pc + 16'd1;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.exec = 1'b0; bus.step = 1'b0; bus.halt_in = 1'b0;
    bus.bp_en = 1'b0; bus.bp_addr = 16'h0000; bus.pc = 16'h0000;
    repeat (2) @(negedge clk);
    checks++; if (bus.phase !== 3'd0)        begin fails++; $display("FAIL reset_phase: got %0d want 0", bus.phase); end
    checks++; if (bus.executing !== 1'b0)    begin fails++; $display("FAIL reset_executing: got %b want 0", bus.executing); end
    checks++; if (bus.ir_load !== 1'b0)      begin fails++; $display("FAIL reset_ir_load: got %b want 0", bus.ir_load); end
    checks++; if (bus.pc_e !== 1'b0)         begin fails++; $display("FAIL reset_pc_e: got %b want 0", bus.pc_e); end
    checks++; if (bus.stop_cause !== 2'd0)   begin fails++; $display("FAIL reset_stop_cause: got %0d want 0", bus.stop_cause); end
    checks++; if (bus.instr_count !== 16'd0) begin fails++; $display("FAIL reset_instr_count: got %0h want 0", bus.instr_count); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.phase !== 3'd0) begin fails++; $display("FAIL idle_after_reset: got %0d want 0", bus.phase); end
  endtask

  // Exec held 4 cycles: start latency, phase order, strobes, and no second start.
  task automatic test_run_sequence();
    int exp_ph [15] = '{0, 0, 0, 1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 1, 2};
    int ph;
    foreach (exp_ph[k]) trace_q.push_back(exp_ph[k]);
    bus.exec = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 3) bus.exec = 1'b0;
      ph = trace_q.pop_front();
      checks++; if (bus.phase !== 3'(ph))          begin fails++; $display("FAIL seq_phase[%0d]: got %0d want %0d", i, bus.phase, ph); end
      checks++; if (bus.ir_load !== (ph == 1))     begin fails++; $display("FAIL seq_ir_load[%0d]: got %b want %b", i, bus.ir_load, (ph == 1)); end
      checks++; if (bus.pc_e !== (ph == 4))        begin fails++; $display("FAIL seq_pc_e[%0d]: got %b want %b", i, bus.pc_e, (ph == 4)); end
      checks++; if (bus.executing !== (ph != 0))   begin fails++; $display("FAIL seq_executing[%0d]: got %b want %b", i, bus.executing, (ph != 0)); end
    end
  endtask

  // Entered at phase 2 of the third instruction; that instruction still completes.
  task automatic test_user_stop();
    bit    to;
    stop_t e;
    stop_q.push_back('{cause: 2'd1, count: 16'd3});
    press(1'b0);
    run_until_idle(40, to);
    e = stop_q.pop_front();
    checks++; if (to)                         begin fails++; $display("FAIL user_stop_timeout: got running want idle"); end
    checks++; if (bus.phase !== 3'd0)         begin fails++; $display("FAIL user_stop_phase: got %0d want 0", bus.phase); end
    checks++; if (bus.stop_cause !== e.cause) begin fails++; $display("FAIL user_stop_cause: got %0d want %0d", bus.stop_cause, e.cause); end
    checks++; if (bus.instr_count !== e.count) begin fails++; $display("FAIL user_stop_count: got %0h want %0h", bus.instr_count, e.count); end
  endtask

  task automatic test_single_step();
    bit    to;
    stop_t e;
    bus.pc = 16'h0010;
    stop_q.push_back('{cause: 2'd1, count: 16'd4});
    start_run(1'b1);
    checks++; if (bus.phase !== 3'd1 || bus.ir_load !== 1'b1) begin fails++; $display("FAIL step_start: got phase %0d ir_load %b want 1 1", bus.phase, bus.ir_load); end
    press(1'b1);
    run_until_idle(40, to);
    e = stop_q.pop_front();
    checks++; if (to)                          begin fails++; $display("FAIL step_timeout: got running want idle"); end
    checks++; if (bus.stop_cause !== e.cause)  begin fails++; $display("FAIL step_cause: got %0d want %0d", bus.stop_cause, e.cause); end
    checks++; if (bus.instr_count !== e.count) begin fails++; $display("FAIL step_count: got %0h want %0h", bus.instr_count, e.count); end
    repeat (8) @(negedge clk);
    checks++; if (bus.executing !== 1'b0 || bus.instr_count !== e.count) begin fails++; $display("FAIL step_stays_idle: got exec %b count %0h want 0 %0h", bus.executing, bus.instr_count, e.count); end
  endtask

  task automatic test_halt();
    stop_t e;
    bus.pc = 16'h0000;
    stop_q.push_back('{cause: 2'd2, count: 16'd7});
    start_run(1'b0);
    repeat (14) @(negedge clk);
    checks++; if (bus.executing !== 1'b1 || bus.phase !== 3'd5) begin fails++; $display("FAIL halt_pre: got exec %b phase %0d want 1 5", bus.executing, bus.phase); end
    bus.halt_in = 1'b1;
    @(negedge clk);
    bus.halt_in = 1'b0;
    e = stop_q.pop_front();
    checks++; if (bus.executing !== 1'b0)      begin fails++; $display("FAIL halt_executing: got %b want 0", bus.executing); end
    checks++; if (bus.stop_cause !== e.cause)  begin fails++; $display("FAIL halt_cause: got %0d want %0d", bus.stop_cause, e.cause); end
    checks++; if (bus.instr_count !== e.count) begin fails++; $display("FAIL halt_count: got %0h want %0h", bus.instr_count, e.count); end

    // Exec pulse and halt_in meet at the same boundary: the user stop takes priority.
    stop_q.push_back('{cause: 2'd1, count: 16'd8});
    start_run(1'b0);
    @(negedge clk);
    bus.exec = 1'b1;
    @(negedge clk);
    bus.exec = 1'b0;
    repeat (2) @(negedge clk);
    bus.halt_in = 1'b1;
    @(negedge clk);
    bus.halt_in = 1'b0;
    e = stop_q.pop_front();
    checks++; if (bus.executing !== 1'b0)      begin fails++; $display("FAIL coincide_executing: got %b want 0", bus.executing); end
    checks++; if (bus.stop_cause !== e.cause)  begin fails++; $display("FAIL coincide_cause: got %0d want %0d", bus.stop_cause, e.cause); end
    checks++; if (bus.instr_count !== e.count) begin fails++; $display("FAIL coincide_count: got %0h want %0h", bus.instr_count, e.count); end
  endtask

  task automatic test_breakpoint();
    bit    to;
    stop_t e;
    bus.pc = 16'h0000; bus.bp_addr = 16'h0004; bus.bp_en = 1'b1;
    stop_q.push_back('{cause: 2'd3, count: 16'd12});
    start_run(1'b0);
    run_until_idle(200, to);
    e = stop_q.pop_front();
    checks++; if (to)                          begin fails++; $display("FAIL bp_timeout: got running want idle"); end
    checks++; if (bus.stop_cause !== e.cause)  begin fails++; $display("FAIL bp_cause: got %0d want %0d", bus.stop_cause, e.cause); end
    checks++; if (bus.instr_count !== e.count) begin fails++; $display("FAIL bp_count: got %0h want %0h", bus.instr_count, e.count); end

    // Resume while sitting on the breakpoint address; only a fresh match stops it.
    bus.bp_addr = 16'h0006;
    stop_q.push_back('{cause: 2'd3, count: 16'd14});
    start_run(1'b0);
    checks++; if (bus.executing !== 1'b1 || bus.stop_cause !== 2'd0) begin fails++; $display("FAIL bp_resume: got exec %b cause %0d want 1 0", bus.executing, bus.stop_cause); end
    run_until_idle(200, to);
    e = stop_q.pop_front();
    checks++; if (to)                          begin fails++; $display("FAIL bp2_timeout: got running want idle"); end
    checks++; if (bus.stop_cause !== e.cause)  begin fails++; $display("FAIL bp2_cause: got %0d want %0d", bus.stop_cause, e.cause); end
    checks++; if (bus.instr_count !== e.count) begin fails++; $display("FAIL bp2_count: got %0h want %0h", bus.instr_count, e.count); end
    bus.bp_en = 1'b0;
  endtask

  task automatic test_async_reset_wrap();
    bit    to;
    stop_t e;
    start_run(1'b0);
    repeat (2) @(negedge clk);
    checks++; if (bus.phase !== 3'd3) begin fails++; $display("FAIL arst_pre_phase: got %0d want 3", bus.phase); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.phase !== 3'd0)        begin fails++; $display("FAIL arst_phase: got %0d want 0", bus.phase); end
    checks++; if (bus.executing !== 1'b0)    begin fails++; $display("FAIL arst_executing: got %b want 0", bus.executing); end
    checks++; if (bus.ir_load !== 1'b0 || bus.pc_e !== 1'b0) begin fails++; $display("FAIL arst_strobes: got %b %b want 0 0", bus.ir_load, bus.pc_e); end
    checks++; if (bus.stop_cause !== 2'd0)   begin fails++; $display("FAIL arst_cause: got %0d want 0", bus.stop_cause); end
    checks++; if (bus.instr_count !== 16'd0) begin fails++; $display("FAIL arst_count: got %0h want 0", bus.instr_count); end
    #1 rst = 1'b0;
    @(negedge clk);

    force dut.instr_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.instr_count_q;
    @(negedge clk);
    checks++; if (bus.instr_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: got %0h want ffff", bus.instr_count); end
    stop_q.push_back('{cause: 2'd1, count: 16'h0000});
    start_run(1'b1);
    run_until_idle(40, to);
    e = stop_q.pop_front();
    checks++; if (to)                          begin fails++; $display("FAIL wrap_timeout: got running want idle"); end
    checks++; if (bus.instr_count !== e.count) begin fails++; $display("FAIL wrap_count: got %0h want %0h", bus.instr_count, e.count); end
    checks++; if (bus.stop_cause !== e.cause)  begin fails++; $display("FAIL wrap_cause: got %0d want %0d", bus.stop_cause, e.cause); end
  endtask

  initial begin
    test_reset();
    test_run_sequence();
    test_user_stop();
    test_single_step();
    test_halt();
    test_breakpoint();
    test_async_reset_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish within 200us");
    $fatal(1, "watchdog expired");
  end
endmodule
